result_arbiter: RTL and testbench

RESULT_ARBITER -- requirements
Module: result_arbiter

---
 rtl/result_arbiter.sv | 92 +++++++++
 tb/tb_result_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_arbiter.sv
// Result arbiter: per-source FIFOs merged onto one result bus
// by round-robin selection, with flush and synchronous reset.
module result_arbiter #(
    parameter int N_SRC    = 5,
    parameter int DEPTH    = 2,
    parameter int W_RESULT = 64
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      flash,
    input  logic [N_SRC-1:0]          src_en,
    input  logic [N_SRC*W_RESULT-1:0] src_msg,
    output logic [N_SRC-1:0]          src_reject,
    output logic                      out_en,
    output logic [W_RESULT-1:0]       out_msg,
    input  logic                      out_reject
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [RW:0]   NSRC    = (RW+1)'(N_SRC);
    localparam logic [RW-1:0] LAST    = RW'(N_SRC - 1);
    localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

    logic [W_RESULT-1:0] mem [N_SRC][DEPTH];
    logic [AW:0]         wr_ptr [N_SRC];
    logic [AW:0]         rd_ptr [N_SRC];
    logic [N_SRC-1:0]    full;
    logic [N_SRC-1:0]    empty;
    logic [N_SRC-1:0]    push;
    logic [RW-1:0]       rr_ptr;
    logic [RW-1:0]       winner;
    logic [RW-1:0]       rr_next;
    logic [RW:0]         idx;
    logic                pop;

    always_comb begin
        full  = '0;
        empty = '0;
        push  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                       (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            push[i]  = src_en[i] & ~full[i] & ~flash;
        end
    end

    // Scan downward so the source closest to rr_ptr is assigned last.
    always_comb begin
        winner = rr_ptr;
        idx    = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (RW+1)'(k);
            if (idx >= NSRC)
                idx = idx - NSRC;
            if (!empty[idx[RW-1:0]])
                winner = idx[RW-1:0];
        end
    end

    assign rr_next    = (winner == LAST) ? '0 : winner + 1'b1;
    assign src_reject = full;
    assign out_en     = ~&empty & ~flash;
    assign pop        = out_en & ~out_reject;
    assign out_msg    = mem[winner][rd_ptr[winner][AW-1:0]];

    always_ff @(posedge clock) begin
        if (!reset_n || flash) begin
            for (int i = 0; i < N_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            rr_ptr <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++)
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
            if (pop) begin
                rd_ptr[winner] <= rd_ptr[winner] + PTR_ONE;
                rr_ptr         <= rr_next;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < N_SRC; i++)
            if (push[i] && reset_n)
                mem[i][wr_ptr[i][AW-1:0]] <= src_msg[i*W_RESULT +: W_RESULT];
    end

endmodule

// File: tb/tb_result_arbiter.sv
// Self-checking bench for result_arbiter: directed scenarios plus
// randomized traffic against a queue-level reference model.
module tb_result_arbiter;

    localparam int N = 5;
    localparam int D = 2;
    localparam int W = 64;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             flash;
    logic [N-1:0]     src_en;
    logic [N*W-1:0]   src_msg;
    logic [N-1:0]     src_reject;
    logic             out_en;
    logic [W-1:0]     out_msg;
    logic             out_reject;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] mbuf [N][D];
    int           mcnt [N];
    int           mrr;

    result_arbiter #(.N_SRC(N), .DEPTH(D), .W_RESULT(W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flash      (flash),
        .src_en     (src_en),
        .src_msg    (src_msg),
        .src_reject (src_reject),
        .out_en     (out_en),
        .out_msg    (out_msg),
        .out_reject (out_reject)
    );

    always #5 clock = ~clock;

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    task automatic set_msg(input int s, input logic [W-1:0] v);
        src_msg[s*W +: W] = v;
    endtask

    task automatic do_reset;
        reset_n    = 1'b0;
        flash      = 1'b0;
        src_en     = '0;
        src_msg    = '0;
        out_reject = 1'b0;
        cyc();
        reset_n = 1'b1;
    endtask

    task automatic model_clear;
        for (int i = 0; i < N; i++) mcnt[i] = 0;
        mrr = 0;
    endtask

    // Apply the inputs currently driven to the queue model, as at the next edge.
    task automatic model_commit(input logic exp_en, input int w);
        int full_pre [N];
        for (int i = 0; i < N; i++) full_pre[i] = (mcnt[i] == D) ? 1 : 0;
        if (!reset_n || flash) begin
            model_clear();
        end else begin
            if (exp_en && !out_reject) begin
                for (int j = 0; j < D - 1; j++) mbuf[w][j] = mbuf[w][j+1];
                mcnt[w]--;
                mrr = (w + 1) % N;
            end
            for (int i = 0; i < N; i++)
                if (src_en[i] && full_pre[i] == 0) begin
                    mbuf[i][mcnt[i]] = src_msg[i*W +: W];
                    mcnt[i]++;
                end
        end
    endtask

    task automatic test_reset;
        reset_n    = 1'b0;
        flash      = 1'b0;
        src_en     = '1;
        src_msg    = '1;
        out_reject = 1'b1;
        cyc();
        cyc();
        src_en  = '0;
        reset_n = 1'b1;
        #1;
        checks++;
        if (out_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_en got=%b exp=0", out_en);
        end
        checks++;
        if (src_reject !== '0) begin
            errors++;
            $display("FAIL reset_src_reject got=%b exp=0", src_reject);
        end
        out_reject = 1'b0;
    endtask

    task automatic test_single;
        do_reset();
        src_en[0] = 1'b1;
        set_msg(0, 64'd3);
        #1;
        checks++;
        if (out_en !== 1'b0) begin
            errors++;
            $display("FAIL single_no_bypass got=%b exp=0", out_en);
        end
        cyc();
        src_en = '0;
        #1;
        checks++;
        if (out_en !== 1'b1 || out_msg !== 64'd3) begin
            errors++;
            $display("FAIL single_out got en=%b msg=%0d exp en=1 msg=3",
                     out_en, out_msg);
        end
        cyc();
        #1;
        checks++;
        if (out_en !== 1'b0) begin
            errors++;
            $display("FAIL single_drained got=%b exp=0", out_en);
        end
    endtask

    task automatic test_fairness;
        logic [W-1:0] exp_ids [3];
        exp_ids[0] = 64'd100;
        exp_ids[1] = 64'd102;
        exp_ids[2] = 64'd104;
        do_reset();
        src_en = 5'b10101;
        set_msg(0, 64'd100);
        set_msg(2, 64'd102);
        set_msg(4, 64'd104);
        cyc();
        src_en = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (out_en !== 1'b1 || out_msg !== exp_ids[k]) begin
                errors++;
                $display("FAIL fair_order[%0d] got en=%b msg=%0d exp=%0d",
                         k, out_en, out_msg, exp_ids[k]);
            end
            cyc();
        end
        #1;
        checks++;
        if (out_en !== 1'b0) begin
            errors++;
            $display("FAIL fair_drained got=%b exp=0", out_en);
        end
        // rr_ptr back at 0: source 0 must beat source 4.
        src_en = 5'b10001;
        set_msg(0, 64'd200);
        set_msg(4, 64'd204);
        cyc();
        src_en = '0;
        #1;
        checks++;
        if (out_msg !== 64'd200) begin
            errors++;
            $display("FAIL fair_rr_zero got=%0d exp=200", out_msg);
        end
        cyc();
        #1;
        checks++;
        if (out_en !== 1'b1 || out_msg !== 64'd204) begin
            errors++;
            $display("FAIL fair_second got en=%b msg=%0d exp=204", out_en, out_msg);
        end
        cyc();
    endtask

    task automatic test_backpressure;
        do_reset();
        out_reject = 1'b1;
        src_en[1]  = 1'b1;
        set_msg(1, 64'd1);
        cyc();
        set_msg(1, 64'd2);
        cyc();
        set_msg(1, 64'd3);
        #1;
        checks++;
        if (src_reject !== 5'b00010) begin
            errors++;
            $display("FAIL bp_full got=%b exp=00010", src_reject);
        end
        checks++;
        if (out_en !== 1'b1 || out_msg !== 64'd1) begin
            errors++;
            $display("FAIL bp_head got en=%b msg=%0d exp=1", out_en, out_msg);
        end
        cyc();
        src_en     = '0;
        out_reject = 1'b0;
        #1;
        checks++;
        if (out_msg !== 64'd1) begin
            errors++;
            $display("FAIL bp_first got=%0d exp=1", out_msg);
        end
        cyc();
        #1;
        checks++;
        if (src_reject[1] !== 1'b0 || out_en !== 1'b1 || out_msg !== 64'd2) begin
            errors++;
            $display("FAIL bp_second got rej=%b en=%b msg=%0d exp rej=0 msg=2",
                     src_reject[1], out_en, out_msg);
        end
        cyc();
        #1;
        checks++;
        if (out_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_third_blocked got=%b exp=0", out_en);
        end
    endtask

    task automatic test_stall;
        do_reset();
        out_reject = 1'b1;
        src_en[3]  = 1'b1;
        set_msg(3, 64'd7);
        cyc();
        src_en = '0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (out_en !== 1'b1 || out_msg !== 64'd7) begin
                errors++;
                $display("FAIL stall_hold[%0d] got en=%b msg=%0d exp=7",
                         k, out_en, out_msg);
            end
            cyc();
        end
        out_reject = 1'b0;
        #1;
        checks++;
        if (out_en !== 1'b1 || out_msg !== 64'd7) begin
            errors++;
            $display("FAIL stall_release got en=%b msg=%0d exp=7", out_en, out_msg);
        end
        cyc();
        #1;
        checks++;
        if (out_en !== 1'b0) begin
            errors++;
            $display("FAIL stall_popped got=%b exp=0", out_en);
        end
    endtask

    task automatic test_flash;
        do_reset();
        out_reject = 1'b1;
        src_en     = 5'b00111;
        set_msg(0, 64'd20);
        set_msg(1, 64'd21);
        set_msg(2, 64'd22);
        cyc();
        src_en = 5'b00001;
        set_msg(0, 64'd23);
        cyc();
        src_en = 5'b01000;
        set_msg(3, 64'd99);
        flash  = 1'b1;
        #1;
        checks++;
        if (out_en !== 1'b0) begin
            errors++;
            $display("FAIL flash_comb_out_en got=%b exp=0", out_en);
        end
        cyc();
        flash      = 1'b0;
        src_en     = '0;
        out_reject = 1'b0;
        #1;
        checks++;
        if (out_en !== 1'b0 || src_reject !== '0) begin
            errors++;
            $display("FAIL flash_after got en=%b rej=%b exp en=0 rej=0",
                     out_en, src_reject);
        end
        for (int k = 0; k < 4; k++) begin
            cyc();
            #1;
            checks++;
            if (out_en !== 1'b0) begin
                errors++;
                $display("FAIL flash_no_leak[%0d] got en=%b msg=%0d exp en=0",
                         k, out_en, out_msg);
            end
        end
    endtask

    task automatic test_reset_stall;
        do_reset();
        out_reject = 1'b1;
        src_en[2]  = 1'b1;
        set_msg(2, 64'd50);
        cyc();
        src_en = '0;
        #1;
        checks++;
        if (out_en !== 1'b1 || out_msg !== 64'd50) begin
            errors++;
            $display("FAIL rst_stall_pending got en=%b msg=%0d exp=50", out_en, out_msg);
        end
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        #1;
        checks++;
        if (out_en !== 1'b0 || src_reject !== '0) begin
            errors++;
            $display("FAIL rst_stall_cleared got en=%b rej=%b exp 0", out_en, src_reject);
        end
        out_reject = 1'b0;
        src_en[2]  = 1'b1;
        set_msg(2, 64'd51);
        cyc();
        src_en = '0;
        #1;
        checks++;
        if (out_en !== 1'b1 || out_msg !== 64'd51) begin
            errors++;
            $display("FAIL rst_stall_new got en=%b msg=%0d exp=51", out_en, out_msg);
        end
        cyc();
        #1;
        checks++;
        if (out_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_stall_only_new got=%b exp=0", out_en);
        end
    endtask

    task automatic test_random;
        logic exp_en;
        int   exp_w;
        int   idx;
        logic [N-1:0] exp_rej;
        do_reset();
        model_clear();
        for (int c = 0; c < 600; c++) begin
            src_en     = N'($urandom);
            for (int i = 0; i < N; i++)
                set_msg(i, {$urandom, 16'(c), 8'(i), 8'hA5});
            out_reject = ($urandom_range(0, 9) < 4);
            flash      = ($urandom_range(0, 49) == 0);
            reset_n    = ($urandom_range(0, 99) != 0);
            #1;
            exp_en = 1'b0;
            exp_w  = 0;
            for (int k = 0; k < N; k++) begin
                idx = (mrr + k) % N;
                if (!exp_en && mcnt[idx] > 0) begin
                    exp_en = 1'b1;
                    exp_w  = idx;
                end
            end
            if (flash) exp_en = 1'b0;
            for (int i = 0; i < N; i++) exp_rej[i] = (mcnt[i] == D);
            checks++;
            if (out_en !== exp_en) begin
                errors++;
                $display("FAIL rand_out_en c=%0d got=%b exp=%b", c, out_en, exp_en);
            end
            if (exp_en) begin
                checks++;
                if (out_msg !== mbuf[exp_w][0]) begin
                    errors++;
                    $display("FAIL rand_out_msg c=%0d got=%h exp=%h",
                             c, out_msg, mbuf[exp_w][0]);
                end
            end
            checks++;
            if (src_reject !== exp_rej) begin
                errors++;
                $display("FAIL rand_src_reject c=%0d got=%b exp=%b",
                         c, src_reject, exp_rej);
            end
            model_commit(exp_en, exp_w);
            cyc();
        end
        src_en  = '0;
        flash   = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        flash      = 1'b0;
        src_en     = '0;
        src_msg    = '0;
        out_reject = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_stall();
        test_flash();
        test_reset_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
